packet_asm: RTL
===============

Name: packet_asm

Overview:
Parametrised packet assembler. It collects NUM_BYTES words of BYTE_W bits from a byte-level receiver, such as the Manchester RX strobe/data pair, into one packet word. The block generalises the fixed 3-byte packet receiver and adds three things:
- a double-buffered output with valid/ack handshake,
- an inter-byte timeout that discards partial packets,
- overflow detection.

It sits between the serial byte receiver and the packet consumer.

Parameters:
NUM_BYTES, 3, bytes per packet (>=1)
BYTE_W, 8, bits per byte (>=1)
TIMEOUT_CYC, 1024, idle clocks allowed between bytes of one packet; 0 disables timeout

Ports:
clk  input  1  system clock, all logic on posedge
rst  input  1  asynchronous active-high reset
byte_vld  input  1  one-cycle strobe, byte_data valid
byte_data  input  BYTE_W  received byte
pckt_ack  input  1  consumer has taken pckt; ignored when pckt_rdy=0
pckt_rdy  output  1  pckt holds a complete packet, held until acked
pckt  output  NUM_BYTES*BYTE_W  assembled packet, first-received byte in MSBs
byte_cnt  output  clog2(NUM_BYTES+1)  bytes collected in current partial packet
timeout  output  1  one-cycle pulse, partial packet discarded
ovfl  output  1  one-cycle pulse, completed packet dropped because output still full

Behaviour:
Reset (async, rst=1):
- state=IDLE; byte_cnt=0; timer=0; pckt_rdy=0; pckt=0; timeout=0; ovfl=0.
- The assembly shift register is cleared.

State machine, two states: IDLE and ASSEMBLE.
- IDLE, byte_vld=1, NUM_BYTES>1: shift byte in, byte_cnt=1, timer=0, go to ASSEMBLE.
- ASSEMBLE, byte_vld=1, byte_cnt<NUM_BYTES-1: shift in, byte_cnt+1, timer=0.
- ASSEMBLE, byte_vld=1, byte_cnt==NUM_BYTES-1: packet complete. Transfer per output rule, byte_cnt=0, go to IDLE.
- ASSEMBLE, byte_vld=0: timer+1.
- ASSEMBLE, byte_vld=0, timer==TIMEOUT_CYC-1 (TIMEOUT_CYC>0): discard, byte_cnt=0, timer=0, timeout=1 next cycle, go to IDLE.
- A byte arriving in the expiry cycle wins: it is accepted and no timeout occurs.
- TIMEOUT_CYC=0: timer frozen, no timeout ever.
- NUM_BYTES=1: every byte_vld completes a packet directly from IDLE; ASSEMBLE is never entered.

Assembly register:
- Left shift by BYTE_W on each accepted byte; the new byte enters the LSBs.
- Result: byte 0 lands in pckt[N*W-1 -: W] and the last byte in pckt[W-1:0].

Output buffer (separate register from the assembly register):
- Completion with pckt_rdy=0: load pckt, pckt_rdy=1 on the next edge. Latency is 1 clock after the edge that accepts the last byte.
- Completion with pckt_rdy=1 and pckt_ack=1 in the same cycle: load the new packet, pckt_rdy stays 1, no ovfl.
- Completion with pckt_rdy=1 and pckt_ack=0: new packet dropped, pckt unchanged, ovfl=1 for one cycle.
- pckt_ack=1 with pckt_rdy=1 and no completion: pckt_rdy=0 on the next edge. pckt holds its last value.
- Assembly continues while the output is full, so one packet can be buffered while the next is in flight.

Other rules:
- timeout and ovfl are registered one-cycle pulses. They are never asserted together, since completion and timeout are mutually exclusive.
- byte_data is sampled only when byte_vld=1.
- Reset mid-packet discards the partial packet and any pending output immediately.

Test Plan:
- NUM_BYTES=3, BYTE_W=8: bytes A5,3C,F0 on consecutive strobes -> pckt_rdy=1 one clock after third strobe, pckt=24'hA53CF0, byte_cnt back to 0.
- Packet pending, no ack; send 11,22,33 -> ovfl pulse one cycle, pckt stays A53CF0. Then ack -> pckt_rdy=0.
- Ack in the same cycle as the last byte of 44,55,66 while the previous packet is pending -> pckt=445566, pckt_rdy stays 1, no ovfl.
- TIMEOUT_CYC=16: send 01,02 then idle 16 clocks -> timeout pulse, byte_cnt=0. Then 07,08,09 -> pckt=070809.
- Byte strobed exactly on the expiry cycle (15 idle clocks after previous byte) -> accepted, no timeout, byte_cnt increments.
- Assert rst after 2 bytes with a packet pending -> pckt_rdy=0, byte_cnt=0, pckt=0 immediately (asynchronous). NUM_BYTES=1 instance: each strobe of BE -> pckt=8'hBE, pckt_rdy next clock.

Source files
------------

// File: rtl/packet_asm_if.sv
// rtl/packet_asm_if.sv - byte-in / packet-out handshake bundle for packet_asm
interface packet_asm_if #(
    parameter int NUM_BYTES = 3,
    parameter int BYTE_W    = 8
) ();
    localparam int PW = NUM_BYTES * BYTE_W;
    localparam int CW = $clog2(NUM_BYTES + 1);

    logic          byte_vld;
    logic [BYTE_W-1:0] byte_data;
    logic          pckt_ack;
    logic          pckt_rdy;
    logic [PW-1:0] pckt;
    logic [CW-1:0] byte_cnt;
    logic          timeout;
    logic          ovfl;

    // Byte source and packet consumer side
    modport master (
        output byte_vld, byte_data, pckt_ack,
        input  pckt_rdy, pckt, byte_cnt, timeout, ovfl
    );

    // Assembler side
    modport slave (
        input  byte_vld, byte_data, pckt_ack,
        output pckt_rdy, pckt, byte_cnt, timeout, ovfl
    );
endinterface

// File: rtl/packet_asm.sv
// rtl/packet_asm.sv - byte-to-packet assembler with buffered output, timeout and overflow
module packet_asm #(
    parameter int NUM_BYTES   = 3,
    parameter int BYTE_W      = 8,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic        clk,
    input  logic        rst,
    packet_asm_if.slave bus
);
    localparam int PW = NUM_BYTES * BYTE_W;
    localparam int CW = $clog2(NUM_BYTES + 1);
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    localparam logic [CW-1:0] LAST_CNT  = CW'(NUM_BYTES - 1);
    localparam logic [TW-1:0] TIMER_MAX = TW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_ASM  = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [PW-1:0] asm_q, asm_d;
    logic [PW-1:0] pckt_q, pckt_d;
    logic          rdy_q, rdy_d;
    logic          timeout_q, timeout_d;
    logic          ovfl_q, ovfl_d;

    logic [PW-1:0] asm_shift;
    logic          complete;

    // Oldest byte migrates toward the MSBs as new bytes enter at the bottom
    assign asm_shift = (asm_q << BYTE_W) | PW'(bus.byte_data);
    // cnt_q is 0 in IDLE, so a single-byte packet completes straight from IDLE
    assign complete  = bus.byte_vld && (cnt_q == LAST_CNT);

    // Next-state: assembly, inter-byte timer and output buffer handshake
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        timer_d   = timer_q;
        asm_d     = asm_q;
        pckt_d    = pckt_q;
        rdy_d     = rdy_q;
        timeout_d = 1'b0;
        ovfl_d    = 1'b0;

        if (complete) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            timer_d = '0;
            asm_d   = '0;
            // A same-cycle ack frees the buffer, so the new packet replaces the old one
            if (!rdy_q || bus.pckt_ack) begin
                pckt_d = asm_shift;
                rdy_d  = 1'b1;
            end else begin
                ovfl_d = 1'b1;
            end
        end else begin
            if (rdy_q && bus.pckt_ack) begin
                rdy_d = 1'b0;
            end
            if (bus.byte_vld) begin
                state_d = S_ASM;
                asm_d   = asm_shift;
                cnt_d   = cnt_q + CW'(1);
                timer_d = '0;
            end else if (state_q == S_ASM && TIMEOUT_CYC > 0) begin
                if (timer_q == TIMER_MAX) begin
                    state_d   = S_IDLE;
                    cnt_d     = '0;
                    timer_d   = '0;
                    asm_d     = '0;
                    timeout_d = 1'b1;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
        end
    end

    // State registers with asynchronous clear of partial and pending packets
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            timer_q   <= '0;
            asm_q     <= '0;
            pckt_q    <= '0;
            rdy_q     <= 1'b0;
            timeout_q <= 1'b0;
            ovfl_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            timer_q   <= timer_d;
            asm_q     <= asm_d;
            pckt_q    <= pckt_d;
            rdy_q     <= rdy_d;
            timeout_q <= timeout_d;
            ovfl_q    <= ovfl_d;
        end
    end

    assign bus.pckt_rdy = rdy_q;
    assign bus.pckt     = pckt_q;
    assign bus.byte_cnt = cnt_q;
    assign bus.timeout  = timeout_q;
    assign bus.ovfl     = ovfl_q;
endmodule
